fetch_unit: RTL

Instruction-fetch stage of the pipelined processor. It owns the architectural PC register, drives the instruction-memory request/acknowledge handshake, and loads the IF/ID pipeline register. It sits directly upstream of PC control: `pc` feeds PC control's current-PC input, and PC control's computed next PC returns on `next_pc`. Branch redirects and hazard stalls from ID flush or hold the stage.

---
 rtl/fetch_unit.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, imem request/ack handshake and IF/ID register.
// Optional FETCH_SKID_EN keeps a stall-time ack in a skid buffer instead of refetching it.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [3:0]  HALT_OPC = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] next_pc,
    input  logic        branch_taken,
    input  logic        stall,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    output logic [15:0] pc,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc_plus2,
    output logic        ifid_valid,
    output logic        halted
);

`ifdef FETCH_SKID_EN
    typedef enum logic [1:0] {S_FETCH, S_DRAIN, S_HOLD, S_HALTED} state_t;
`else
    typedef enum logic [1:0] {S_FETCH, S_DRAIN, S_RETRY, S_HALTED} state_t;
`endif

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] req_addr_q, req_addr_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pc2_q, pc2_d;
    logic        valid_q, valid_d;
`ifdef FETCH_SKID_EN
    logic [15:0] skid_instr_q, skid_instr_d;
    logic [15:0] skid_pc2_q, skid_pc2_d;
`endif

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc2_d    = pc2_q;
        valid_d  = valid_q;
`ifdef FETCH_SKID_EN
        skid_instr_d = skid_instr_q;
        skid_pc2_d   = skid_pc2_q;
`endif
        imem_req = 1'b0;
        halted   = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (branch_taken) begin
                    pc_d    = next_pc;
                    valid_d = 1'b0;
                    state_d = imem_ack ? S_FETCH : S_DRAIN;
                end else if (imem_ack && stall) begin
`ifdef FETCH_SKID_EN
                    skid_instr_d = imem_data;
                    skid_pc2_d   = req_addr_q + 16'd2;
                    state_d      = S_HOLD;
`else
                    state_d      = S_RETRY;
`endif
                end else if (imem_ack) begin
                    instr_d = imem_data;
                    pc2_d   = req_addr_q + 16'd2;
                    valid_d = 1'b1;
                    pc_d    = next_pc;
                    if (imem_data[15:12] == HALT_OPC) begin
                        state_d = S_HALTED;
                    end
                end else if (!stall) begin
                    // ID took the previous instruction and nothing new arrived: bubble
                    valid_d = 1'b0;
                end
            end
            S_DRAIN: begin
                imem_req = 1'b1;
                if (branch_taken) begin
                    pc_d = next_pc;
                end
                if (imem_ack) begin
                    state_d = S_FETCH;
                end
            end
`ifdef FETCH_SKID_EN
            S_HOLD: begin
                if (branch_taken) begin
                    pc_d    = next_pc;
                    valid_d = 1'b0;
                    state_d = S_FETCH;
                end else if (!stall) begin
                    instr_d = skid_instr_q;
                    pc2_d   = skid_pc2_q;
                    valid_d = 1'b1;
                    pc_d    = next_pc;
                    state_d = (skid_instr_q[15:12] == HALT_OPC) ? S_HALTED : S_FETCH;
                end
            end
`else
            S_RETRY: begin
                if (branch_taken) begin
                    pc_d    = next_pc;
                    valid_d = 1'b0;
                    state_d = S_FETCH;
                end else if (!stall) begin
                    valid_d = 1'b0;
                    state_d = S_FETCH;
                end
            end
`endif
            S_HALTED: begin
                halted = 1'b1;
                if (branch_taken) begin
                    pc_d    = next_pc;
                    valid_d = 1'b0;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // A fresh request latches the PC it will fetch; an outstanding one keeps its address
        if (state_d == S_FETCH && !(state_q == S_FETCH && !imem_ack)) begin
            req_addr_d = pc_d;
        end else begin
            req_addr_d = req_addr_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            instr_q    <= 16'h0000;
            pc2_q      <= 16'h0000;
            valid_q    <= 1'b0;
`ifdef FETCH_SKID_EN
            skid_instr_q <= 16'h0000;
            skid_pc2_q   <= 16'h0000;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            instr_q    <= instr_d;
            pc2_q      <= pc2_d;
            valid_q    <= valid_d;
`ifdef FETCH_SKID_EN
            skid_instr_q <= skid_instr_d;
            skid_pc2_q   <= skid_pc2_d;
`endif
        end
    end

    assign imem_addr     = req_addr_q;
    assign pc            = pc_q;
    assign ifid_instr    = instr_q;
    assign ifid_pc_plus2 = pc2_q;
    assign ifid_valid    = valid_q;

endmodule
